// File: rtl/demux2_32_reg.sv
// Registered 1-to-2 demultiplexer with a valid/ready handshake and one holding register per channel.
// Define DEMUX2_32_REG_COUNT_EN to add per-channel 8-bit output-transfer counters (count_a, count_b).
module demux2_32_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             select,
   output logic             out_a_valid,
   input  logic             out_a_ready,
   output logic [WIDTH-1:0] out_a,
   output logic             out_b_valid,
   input  logic             out_b_ready,
   output logic [WIDTH-1:0] out_b
`ifdef DEMUX2_32_REG_COUNT_EN
   ,
   output logic [7:0]       count_a,
   output logic [7:0]       count_b
`endif
);

   logic in_fire;
   logic load_a;
   logic load_b;
   logic drain_a;
   logic drain_b;

   // Readiness looks only at the selected channel, so a stall on the other never blocks this one.
   always_comb begin
      in_ready = select ? (!out_b_valid || out_b_ready)
                        : (!out_a_valid || out_a_ready);
      in_fire  = in_valid && in_ready;
      load_a   = in_fire && !select;
      load_b   = in_fire && select;
      drain_a  = out_a_valid && out_a_ready;
      drain_b  = out_b_valid && out_b_ready;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_a_valid <= 1'b0;
         out_a       <= '0;
      end else if (load_a) begin
         out_a_valid <= 1'b1;
         out_a       <= in_data;
      end else if (drain_a) begin
         out_a_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_b_valid <= 1'b0;
         out_b       <= '0;
      end else if (load_b) begin
         out_b_valid <= 1'b1;
         out_b       <= in_data;
      end else if (drain_b) begin
         out_b_valid <= 1'b0;
      end
   end

`ifdef DEMUX2_32_REG_COUNT_EN
   // Counters wrap naturally at 8 bits.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_a <= 8'd0;
         count_b <= 8'd0;
      end else begin
         if (drain_a) begin
            count_a <= count_a + 8'd1;
         end
         if (drain_b) begin
            count_b <= count_b + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_demux2_32_reg.sv
// Scoreboard bench for demux2_32_reg: directed stimulus pushes expected words per channel,
// and a monitor pops and compares on every output transfer.
module tb_demux2_32_reg;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        select;
   logic        out_a_valid;
   logic        out_a_ready;
   logic [31:0] out_a;
   logic        out_b_valid;
   logic        out_b_ready;
   logic [31:0] out_b;
`ifdef DEMUX2_32_REG_COUNT_EN
   logic [7:0]  count_a;
   logic [7:0]  count_b;
`endif

   logic [31:0] queue_a[$];
   logic [31:0] queue_b[$];
   int compared;
   int mismatched;

   demux2_32_reg #(.WIDTH(32)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .select      (select),
      .out_a_valid (out_a_valid),
      .out_a_ready (out_a_ready),
      .out_a       (out_a),
      .out_b_valid (out_b_valid),
      .out_b_ready (out_b_ready),
      .out_b       (out_b)
`ifdef DEMUX2_32_REG_COUNT_EN
      ,
      .count_a     (count_a),
      .count_b     (count_b)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
      end
   endtask

   // Drives all inputs just after a rising edge so they are stable at the next one.
   task automatic applyStimulus(input logic v, input logic sel, input logic [31:0] d,
                                input logic ra, input logic rb);
      @(posedge clock);
      #1;
      in_valid    = v;
      select      = sel;
      in_data     = d;
      out_a_ready = ra;
      out_b_ready = rb;
   endtask

   // Monitor: a transfer is due at the next edge whenever valid and ready are both high mid-cycle.
   always @(negedge clock) begin
      if (!reset) begin
         if (out_a_valid && out_a_ready) begin
            if (queue_a.size() == 0) begin
               checkOutput("a_unexpected_word", out_a, 32'hxxxxxxxx);
            end else begin
               checkOutput("a_data", out_a, queue_a.pop_front());
            end
         end
         if (out_b_valid && out_b_ready) begin
            if (queue_b.size() == 0) begin
               checkOutput("b_unexpected_word", out_b, 32'hxxxxxxxx);
            end else begin
               checkOutput("b_data", out_b, queue_b.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      compared    = 0;
      mismatched  = 0;
      reset       = 1'b1;
      in_valid    = 1'b0;
      select      = 1'b0;
      in_data     = 32'h0;
      out_a_ready = 1'b0;
      out_b_ready = 1'b0;

      // Outputs while reset is held.
      repeat (3) @(posedge clock);
      #1;
      checkOutput("rst_a_valid", {31'd0, out_a_valid}, 32'd0);
      checkOutput("rst_b_valid", {31'd0, out_b_valid}, 32'd0);
      checkOutput("rst_a_data", out_a, 32'd0);
      checkOutput("rst_b_data", out_b, 32'd0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Single word to channel a, visible for exactly one cycle.
      applyStimulus(1'b1, 1'b0, 32'h11111111, 1'b1, 1'b0);
      queue_a.push_back(32'h11111111);
      @(negedge clock);
      checkOutput("s1_in_ready", {31'd0, in_ready}, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge clock);
      checkOutput("s1_a_valid", {31'd0, out_a_valid}, 32'd1);
      checkOutput("s1_a_data", out_a, 32'h11111111);
      checkOutput("s1_b_valid", {31'd0, out_b_valid}, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge clock);
      checkOutput("s1_a_valid_drop", {31'd0, out_a_valid}, 32'd0);
      checkOutput("s1_b_valid_still", {31'd0, out_b_valid}, 32'd0);

      // Backpressure on channel b, then release with no bubble.
      applyStimulus(1'b1, 1'b1, 32'hB0000001, 1'b1, 1'b0);
      queue_b.push_back(32'hB0000001);
      @(negedge clock);
      checkOutput("s2_first_in_ready", {31'd0, in_ready}, 32'd1);
      applyStimulus(1'b1, 1'b1, 32'hB0000002, 1'b1, 1'b0);
      @(negedge clock);
      checkOutput("s2_stall_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("s2_stall_b_data", out_b, 32'hB0000001);
      applyStimulus(1'b1, 1'b1, 32'hB0000002, 1'b1, 1'b0);
      @(negedge clock);
      checkOutput("s2_hold_b_data", out_b, 32'hB0000001);
      checkOutput("s2_hold_in_ready", {31'd0, in_ready}, 32'd0);
      applyStimulus(1'b1, 1'b1, 32'hB0000002, 1'b1, 1'b1);
      queue_b.push_back(32'hB0000002);
      @(negedge clock);
      checkOutput("s2_release_in_ready", {31'd0, in_ready}, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge clock);
      checkOutput("s2_no_bubble_valid", {31'd0, out_b_valid}, 32'd1);
      checkOutput("s2_no_bubble_data", out_b, 32'hB0000002);

      // Channel b stalled and full must not block channel a.
      applyStimulus(1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0);
      queue_a.push_back(32'hA5A5A5A5);
      @(negedge clock);
      checkOutput("s3_in_ready", {31'd0, in_ready}, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge clock);
      checkOutput("s3_a_valid", {31'd0, out_a_valid}, 32'd1);
      checkOutput("s3_a_data", out_a, 32'hA5A5A5A5);
      checkOutput("s3_b_held", out_b, 32'hB0000002);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

      // 100-word stream with alternating destination.
      for (int i = 0; i < 100; i++) begin
         logic [31:0] word;
         word = (i[0] ? 32'hB0000000 : 32'hA0000000) | 32'(i);
         applyStimulus(1'b1, i[0], word, 1'b1, 1'b1);
         if (i[0]) queue_b.push_back(word);
         else      queue_a.push_back(word);
         @(negedge clock);
         checkOutput("s4_in_ready", {31'd0, in_ready}, 32'd1);
      end
      repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      @(negedge clock);
      checkOutput("s4_queue_a_drained", 32'(queue_a.size()), 32'd0);
      checkOutput("s4_queue_b_drained", 32'(queue_b.size()), 32'd0);

      // Held word discarded by a mid-cycle reset.
      applyStimulus(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clock);
      checkOutput("s5_held_data", out_a, 32'hDEADBEEF);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("s5_rst_a_valid", {31'd0, out_a_valid}, 32'd0);
      checkOutput("s5_rst_a_data", out_a, 32'd0);
      queue_a.delete();
      queue_b.delete();
      @(posedge clock);
      #1;
      reset = 1'b0;
      out_a_ready = 1'b1;
      @(negedge clock);
      checkOutput("s5_post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         @(negedge clock);
         checkOutput("s5_no_reappear", out_a, 32'd0);
      end

`ifdef DEMUX2_32_REG_COUNT_EN
      // 257 transfers on channel a wraps its counter to 1.
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 257; i++) begin
         applyStimulus(1'b1, 1'b0, 32'hC0000000 | 32'(i), 1'b1, 1'b1);
         queue_a.push_back(32'hC0000000 | 32'(i));
      end
      repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      @(negedge clock);
      checkOutput("s6_count_a", {24'd0, count_a}, 32'd1);
      checkOutput("s6_count_b", {24'd0, count_b}, 32'd0);
`endif

      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      @(negedge clock);
      checkOutput("end_queue_a_empty", 32'(queue_a.size()), 32'd0);
      checkOutput("end_queue_b_empty", 32'(queue_b.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/demux2_32_reg.md
DEMUX2_32_REG -- requirements
Module: demux2_32_reg

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the data path width in bits.
REQ-002 The module SHALL have port clock, input, 1, the only clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1, meaning the source presents a word.
REQ-005 The module SHALL have port in_ready, output, 1, meaning the block accepts the presented word this cycle.
REQ-006 The module SHALL have port in_data, input, WIDTH, the word to route.
REQ-007 The module SHALL have port select, input, 1, the destination: 0 routes to channel a, 1 routes to channel b.
REQ-008 The module SHALL have ports out_a_valid and out_b_valid, output, 1 each, meaning the channel holds a word.
REQ-009 The module SHALL have ports out_a_ready and out_b_ready, input, 1 each, meaning the sink takes the held word.
REQ-010 The module SHALL have ports out_a and out_b, output, WIDTH each, the held words.

Function
REQ-011 Each channel SHALL contain one holding register (a valid flag plus WIDTH data bits), driven directly onto its out_x_valid and out_x ports.
REQ-012 An input transfer SHALL occur when in_valid and in_ready are both 1 at a rising clock edge.
REQ-013 An output transfer on channel x SHALL occur when out_x_valid and out_x_ready are both 1 at a rising clock edge.
REQ-014 in_ready SHALL be combinational and equal to: the selected channel's valid flag is 0, or the selected channel's out_x_ready is 1.
REQ-015 in_ready SHALL NOT depend on the state of the unselected channel.
REQ-016 On an input transfer, the selected channel SHALL load in_data and set its valid flag on the same edge, giving 1-cycle latency from input to output.
REQ-017 On an output transfer with no input transfer to the same channel, that channel's valid flag SHALL clear.
REQ-018 On a simultaneous output transfer and input transfer to the same channel, the channel's valid flag SHALL stay 1 and its data SHALL take the new word, with no bubble.
REQ-019 A channel whose valid flag is 1 and that has no output transfer SHALL hold its data unchanged, regardless of in_data or select.
REQ-020 The two channels SHALL drain independently; a stall on one channel SHALL never block transfers on the other.
REQ-021 Words routed to the same channel SHALL leave that channel in acceptance order.
REQ-022 When in_valid is 0, in_data and select SHALL be ignored.

Reset
REQ-023 While reset is 1, out_a_valid and out_b_valid SHALL be 0, and out_a and out_b SHALL be all zeros, immediately and without waiting for a clock edge.
REQ-024 In the cycle after reset deasserts, in_ready SHALL be 1.
REQ-025 An assertion of reset mid-stream SHALL discard all held words; no word held at reset SHALL appear on any output afterward.

Configuration
REQ-026 When the macro DEMUX2_32_REG_COUNT_EN is defined, the module SHALL add output ports count_a and count_b, 8 bits each.
REQ-027 When DEMUX2_32_REG_COUNT_EN is defined, count_a and count_b SHALL each increment by 1 on every output transfer of their channel.
REQ-028 When DEMUX2_32_REG_COUNT_EN is defined, count_a and count_b SHALL wrap from 255 to 0 and SHALL reset to 0.
REQ-029 When DEMUX2_32_REG_COUNT_EN is not defined, count_a, count_b and the counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL cover this scenario: with reset held, check outputs. After release, send 0x11111111 with select=0 and out_a_ready=1. Required: out_a=0x11111111 and out_a_valid=1 one cycle later, for exactly one cycle; out_b_valid stays 0.
REQ-031 The bench SHALL cover this scenario: out_b_ready=0, send 0xB0000001 with select=1, then offer 0xB0000002 with select=1. Required: in_ready=0 and out_b holds 0xB0000001. Then raise out_b_ready. Required: 0xB0000002 is accepted and appears on the next edge with no bubble.
REQ-032 The bench SHALL cover this scenario: channel b stalled and full, send 0xA5A5A5A5 with select=0. Required: in_ready=1 and out_a=0xA5A5A5A5 on the next cycle.
REQ-033 The bench SHALL cover this scenario: both out_x_ready=1, stream 100 words with alternating select. Required: each channel delivers its 50 words in order, and in_ready stays 1 throughout.
REQ-034 The bench SHALL cover this scenario: channel a holds 0xDEADBEEF, then assert reset between clock edges. Required: out_a_valid=0 and out_a=0 immediately, and 0xDEADBEEF never reappears.
REQ-035 The bench SHALL cover this scenario: with DEMUX2_32_REG_COUNT_EN defined, perform 257 output transfers on channel a. Required: count_a=1 and count_b=0.
